// File: rtl/sdram_arb_pkg.sv
// Shared constants for the SDRAM command-port arbiter: FSM encoding, default widths
// and the index-wrap helper. Optional feature macro: SDRAM_ARB_PRIO0_EN.
package sdram_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_ACK   = 2'd3;

   localparam int DEF_AW   = 26;
   localparam int DEF_DW   = 16;
   localparam int TO_CNT_W = 8;
   localparam int GID_W    = 3;

   // (base + off) mod n; wraps on the requester count, not on the index width
   function automatic logic [GID_W-1:0] wrap_add(input logic [GID_W-1:0] base,
                                                  input int off, input int n);
      int s;
      s = int'(base) + off;
      return GID_W'(s % n);
   endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request bit searching upward from last+1,
// wrapping modulo NUM_REQ.
module rr_pick
   import sdram_arb_pkg::*;
#(
   parameter int NUM_REQ = 3
)
(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [GID_W-1:0]   i_last,
   output logic [GID_W-1:0]   o_idx,
   output logic               o_found
);

   logic [7:0]       w_req_pad;
   logic [GID_W-1:0] w_cand;

   assign w_req_pad = 8'(i_req);

   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      w_cand  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_cand = wrap_add(i_last, i, NUM_REQ);
         if (!o_found && w_req_pad[w_cand]) begin
            o_found = 1'b1;
            o_idx   = w_cand;
         end
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port among NUM_REQ requesters.
// Define SDRAM_ARB_PRIO0_EN to give requester 0 fixed highest priority.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_REQ     = 3,
   parameter int AW          = DEF_AW,
   parameter int DW          = DEF_DW,
   parameter int TIMEOUT_CYC = 255
)
(
   input  logic                  clkSDRAMcontrol,
   input  logic                  resetn,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_we,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   input  logic [NUM_REQ*DW-1:0] req_wdata,
   input  logic [NUM_REQ*2-1:0]  req_mask,
   output logic [NUM_REQ-1:0]    req_ack,
   output logic [DW-1:0]         req_rdata,
   output logic                  req_err,
   output logic                  ctl_valid,
   input  logic                  ctl_accept,
   output logic                  ctl_we,
   output logic [AW-1:0]         ctl_addr,
   output logic [DW-1:0]         ctl_wdata,
   output logic [1:0]            ctl_mask,
   input  logic                  ctl_done,
   input  logic [DW-1:0]         ctl_rdata,
   output logic [2:0]            grant_id,
   output logic [1:0]            o_dbg_state
);

   // Handshake: the command is transferred on a cycle where ctl_valid && ctl_accept;
   // ctl_valid and all ctl_* fields are held stable from assertion until that cycle.

   localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);

   logic [1:0]          r_state;
   logic [GID_W-1:0]    r_last;
   logic [GID_W-1:0]    r_grant;
   logic [TO_CNT_W-1:0] r_cnt;
   logic                r_ctl_valid;
   logic                r_ctl_we;
   logic [AW-1:0]       r_ctl_addr;
   logic [DW-1:0]       r_ctl_wdata;
   logic [1:0]          r_ctl_mask;
   logic [NUM_REQ-1:0]  r_ack;
   logic                r_err;
   logic [DW-1:0]       r_rdata;

   logic [1:0]          w_state_nxt;
   logic [NUM_REQ-1:0]  w_rr_req;
   logic [GID_W-1:0]    w_rr_idx;
   logic                w_rr_found;
   logic [GID_W-1:0]    w_pick_idx;
   logic                w_pick_found;
   logic                w_pick_upd;
   logic                w_sel_we;
   logic [AW-1:0]       w_sel_addr;
   logic [DW-1:0]       w_sel_wdata;
   logic [1:0]          w_sel_mask;
   logic                w_grant_start;
   logic                w_accepted;
   logic                w_enter_ack;
   logic                w_enter_err;
   logic                w_timeout;
   logic [NUM_REQ-1:0]  w_grant_onehot;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .i_req   (w_rr_req),
      .i_last  (r_last),
      .o_idx   (w_rr_idx),
      .o_found (w_rr_found)
   );

`ifdef SDRAM_ARB_PRIO0_EN
   // Requester 0 bypasses the rotation and leaves the pointer alone when it wins
   assign w_rr_req = {req_valid[NUM_REQ-1:1], 1'b0};

   always_comb begin
      if (req_valid[0]) begin
         w_pick_idx   = '0;
         w_pick_found = 1'b1;
         w_pick_upd   = 1'b0;
      end else begin
         w_pick_idx   = w_rr_idx;
         w_pick_found = w_rr_found;
         w_pick_upd   = w_rr_found;
      end
   end
`else
   assign w_rr_req     = req_valid;
   assign w_pick_idx   = w_rr_idx;
   assign w_pick_found = w_rr_found;
   assign w_pick_upd   = w_rr_found;
`endif

   always_comb begin
      w_sel_we    = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_mask  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_pick_idx == GID_W'(i)) begin
            w_sel_we    = req_we[i];
            w_sel_addr  = req_addr[i*AW +: AW];
            w_sel_wdata = req_wdata[i*DW +: DW];
            w_sel_mask  = req_mask[i*2 +: 2];
         end
      end
   end

   assign w_grant_onehot = NUM_REQ'(1) << r_grant;
   assign w_timeout      = (r_cnt == TO_LAST);
   assign w_grant_start  = (r_state == ST_IDLE) && w_pick_found;
   assign w_accepted     = (r_state == ST_ISSUE) && ctl_accept;

   always_comb begin
      w_state_nxt = r_state;
      w_enter_ack = 1'b0;
      w_enter_err = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_found) w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (ctl_accept) begin
               if (ctl_done) begin
                  w_state_nxt = ST_ACK;
                  w_enter_ack = 1'b1;
               end else begin
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (ctl_done) begin
               w_state_nxt = ST_ACK;
               w_enter_ack = 1'b1;
            end else if (w_timeout) begin
               w_state_nxt = ST_ACK;
               w_enter_ack = 1'b1;
               w_enter_err = 1'b1;
            end
         end
         ST_ACK: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clkSDRAMcontrol or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clkSDRAMcontrol or negedge resetn) begin
      if (!resetn) begin
         r_ctl_we    <= 1'b0;
         r_ctl_addr  <= '0;
         r_ctl_wdata <= '0;
         r_ctl_mask  <= '0;
         r_grant     <= '0;
         r_last      <= GID_W'(NUM_REQ - 1);
      end else if (w_grant_start) begin
         r_ctl_we    <= w_sel_we;
         r_ctl_addr  <= w_sel_addr;
         r_ctl_wdata <= w_sel_wdata;
         r_ctl_mask  <= w_sel_mask;
         r_grant     <= w_pick_idx;
         if (w_pick_upd) r_last <= w_pick_idx;
      end
   end

   always_ff @(posedge clkSDRAMcontrol or negedge resetn) begin
      if (!resetn) begin
         r_ctl_valid <= 1'b0;
      end else if (w_grant_start) begin
         r_ctl_valid <= 1'b1;
      end else if (w_accepted) begin
         r_ctl_valid <= 1'b0;
      end
   end

   // Counts WAIT cycles; WAIT lasts at most TIMEOUT_CYC cycles before the error abort
   always_ff @(posedge clkSDRAMcontrol or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
      end else if (w_accepted) begin
         r_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
         r_cnt <= r_cnt + TO_CNT_W'(1);
      end
   end

   always_ff @(posedge clkSDRAMcontrol or negedge resetn) begin
      if (!resetn) begin
         r_ack   <= '0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack <= w_enter_ack ? w_grant_onehot : '0;
         r_err <= w_enter_err;
         if (w_enter_ack && !w_enter_err && !r_ctl_we) r_rdata <= ctl_rdata;
      end
   end

   assign req_ack     = r_ack;
   assign req_err     = r_err;
   assign req_rdata   = r_rdata;
   assign ctl_valid   = r_ctl_valid;
   assign ctl_we      = r_ctl_we;
   assign ctl_addr    = r_ctl_addr;
   assign ctl_wdata   = r_ctl_wdata;
   assign ctl_mask    = r_ctl_mask;
   assign grant_id    = r_grant;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: cycle table for round-robin, hand sequences
// for read latency, write hold, timeout, async reset and requester-0 priority.
module tb_sdram_port_arbiter;

   localparam int NR = 3;
   localparam int AW = 26;
   localparam int DW = 16;

   logic              clk = 1'b0;
   logic              resetn;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_we;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR*2-1:0]   req_mask;
   logic [NR-1:0]     req_ack;
   logic [DW-1:0]     req_rdata;
   logic              req_err;
   logic              ctl_valid;
   logic              ctl_accept;
   logic              ctl_we;
   logic [AW-1:0]     ctl_addr;
   logic [DW-1:0]     ctl_wdata;
   logic [1:0]        ctl_mask;
   logic              ctl_done;
   logic [DW-1:0]     ctl_rdata;
   logic [2:0]        grant_id;
   logic [1:0]        dbg_state;

   int total = 0;
   int bad   = 0;

   logic [2:0] exp_q[$];

   typedef struct {
      logic [2:0]  valid;
      logic        acc;
      logic        done;
      logic [15:0] rdata;
      logic        cv;
      logic [2:0]  gid;
      logic [2:0]  ack;
      logic [1:0]  st;
      logic [15:0] rd;
   } vec_t;

   vec_t vt[19];

   sdram_port_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .TIMEOUT_CYC(255)) dut (
      .clkSDRAMcontrol (clk),
      .resetn          (resetn),
      .req_valid       (req_valid),
      .req_we          (req_we),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .req_mask        (req_mask),
      .req_ack         (req_ack),
      .req_rdata       (req_rdata),
      .req_err         (req_err),
      .ctl_valid       (ctl_valid),
      .ctl_accept      (ctl_accept),
      .ctl_we          (ctl_we),
      .ctl_addr        (ctl_addr),
      .ctl_wdata       (ctl_wdata),
      .ctl_mask        (ctl_mask),
      .ctl_done        (ctl_done),
      .ctl_rdata       (ctl_rdata),
      .grant_id        (grant_id),
      .o_dbg_state     (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cv"},    32'(ctl_valid), 32'd0);
      check({tag, "_ack"},   32'(req_ack),   32'd0);
      check({tag, "_err"},   32'(req_err),   32'd0);
      check({tag, "_gid"},   32'(grant_id),  32'd0);
      check({tag, "_st"},    32'(dbg_state), 32'd0);
      check({tag, "_we"},    32'(ctl_we),    32'd0);
      check({tag, "_addr"},  32'(ctl_addr),  32'd0);
   endtask

   initial begin
      int n_wait;
      logic [2:0] e;

      // round-robin table: all three requesting, immediate accept+done
      vt[0]  = '{3'b111, 1'b1, 1'b1, 16'hA001, 1'b1, 3'd0, 3'b000, 2'd1, 16'h0000};
      vt[1]  = '{3'b111, 1'b1, 1'b1, 16'hA001, 1'b0, 3'd0, 3'b001, 2'd3, 16'hA001};
      vt[2]  = '{3'b111, 1'b1, 1'b1, 16'hA002, 1'b0, 3'd0, 3'b000, 2'd0, 16'hA001};
      vt[3]  = '{3'b111, 1'b1, 1'b1, 16'hA002, 1'b1, 3'd1, 3'b000, 2'd1, 16'hA001};
      vt[4]  = '{3'b111, 1'b1, 1'b1, 16'hA002, 1'b0, 3'd1, 3'b010, 2'd3, 16'hA002};
      vt[5]  = '{3'b111, 1'b1, 1'b1, 16'hA003, 1'b0, 3'd1, 3'b000, 2'd0, 16'hA002};
      vt[6]  = '{3'b111, 1'b1, 1'b1, 16'hA003, 1'b1, 3'd2, 3'b000, 2'd1, 16'hA002};
      vt[7]  = '{3'b111, 1'b1, 1'b1, 16'hA003, 1'b0, 3'd2, 3'b100, 2'd3, 16'hA003};
      vt[8]  = '{3'b111, 1'b1, 1'b1, 16'hA004, 1'b0, 3'd2, 3'b000, 2'd0, 16'hA003};
      vt[9]  = '{3'b111, 1'b1, 1'b1, 16'hA004, 1'b1, 3'd0, 3'b000, 2'd1, 16'hA003};
      vt[10] = '{3'b111, 1'b1, 1'b1, 16'hA004, 1'b0, 3'd0, 3'b001, 2'd3, 16'hA004};
      vt[11] = '{3'b111, 1'b1, 1'b1, 16'hA005, 1'b0, 3'd0, 3'b000, 2'd0, 16'hA004};
      vt[12] = '{3'b111, 1'b1, 1'b1, 16'hA005, 1'b1, 3'd1, 3'b000, 2'd1, 16'hA004};
      vt[13] = '{3'b111, 1'b1, 1'b1, 16'hA005, 1'b0, 3'd1, 3'b010, 2'd3, 16'hA005};
      vt[14] = '{3'b111, 1'b1, 1'b1, 16'hA006, 1'b0, 3'd1, 3'b000, 2'd0, 16'hA005};
      vt[15] = '{3'b111, 1'b1, 1'b1, 16'hA006, 1'b1, 3'd2, 3'b000, 2'd1, 16'hA005};
      vt[16] = '{3'b111, 1'b1, 1'b1, 16'hA006, 1'b0, 3'd2, 3'b100, 2'd3, 16'hA006};
      vt[17] = '{3'b000, 1'b1, 1'b1, 16'hA007, 1'b0, 3'd2, 3'b000, 2'd0, 16'hA006};
      vt[18] = '{3'b000, 1'b1, 1'b1, 16'hA007, 1'b0, 3'd2, 3'b000, 2'd0, 16'hA006};
`ifdef SDRAM_ARB_PRIO0_EN
      // with requester 0 always asserted it wins every grant
      for (int i = 0; i < 19; i++) begin
         vt[i].gid = 3'd0;
         if (vt[i].ack != 3'b000) vt[i].ack = 3'b001;
      end
`endif

      resetn     = 1'b0;
      req_valid  = '0;
      req_we     = '0;
      req_addr   = '0;
      req_wdata  = '0;
      req_mask   = '0;
      ctl_accept = 1'b0;
      ctl_done   = 1'b0;
      ctl_rdata  = '0;

      step();
      step();
      check_reset_outputs("rst_hold");
      check("rst_hold_rdata", 32'(req_rdata), 32'd0);
      resetn = 1'b1;
      step();
      check_reset_outputs("rst_rel");

      // table-driven round-robin
      for (int i = 0; i < 19; i++) begin
         req_valid  = vt[i].valid;
         ctl_accept = vt[i].acc;
         ctl_done   = vt[i].done;
         ctl_rdata  = vt[i].rdata;
         step();
         check($sformatf("rr%0d_cv", i),  32'(ctl_valid), 32'(vt[i].cv));
         check($sformatf("rr%0d_gid", i), 32'(grant_id),  32'(vt[i].gid));
         check($sformatf("rr%0d_ack", i), 32'(req_ack),   32'(vt[i].ack));
         check($sformatf("rr%0d_st", i),  32'(dbg_state), 32'(vt[i].st));
         check($sformatf("rr%0d_rd", i),  32'(req_rdata), 32'(vt[i].rd));
         check($sformatf("rr%0d_err", i), 32'(req_err),   32'd0);
      end

      // single read: accept 2 cycles after ctl_valid, done 5 cycles later
      ctl_accept = 1'b0;
      ctl_done   = 1'b0;
      req_addr[0 +: AW] = 26'h0000123;
      req_valid  = 3'b001;
      step();
      check("rd_cv", 32'(ctl_valid), 32'd1);
      check("rd_addr", 32'(ctl_addr), 32'h123);
      check("rd_we", 32'(ctl_we), 32'd0);
      check("rd_gid", 32'(grant_id), 32'd0);
      step();
      check("rd_cv_hold", 32'(ctl_valid), 32'd1);
      ctl_accept = 1'b1;
      step();
      check("rd_wait_st", 32'(dbg_state), 32'd2);
      check("rd_cv_drop", 32'(ctl_valid), 32'd0);
      ctl_accept = 1'b0;
      repeat (4) step();
      check("rd_no_ack_yet", 32'(req_ack), 32'd0);
      ctl_done  = 1'b1;
      ctl_rdata = 16'hBEEF;
      step();
      check("rd_ack", 32'(req_ack), 32'b001);
      check("rd_rdata", 32'(req_rdata), 32'hBEEF);
      check("rd_err", 32'(req_err), 32'd0);
      ctl_done  = 1'b0;
      ctl_rdata = 16'h0000;
      req_valid = 3'b000;
      step();
      check("rd_ack_1cyc", 32'(req_ack), 32'd0);
      check("rd_rdata_hold", 32'(req_rdata), 32'hBEEF);

      // write on requester 2, fields held while accept is low
      req_we = 3'b100;
      req_addr[2*AW +: AW] = 26'h0ABCDEF;
      req_wdata[2*DW +: DW] = 16'h5A5A;
      req_mask[4 +: 2] = 2'b10;
      req_valid = 3'b100;
      step();
      check("wr_gid", 32'(grant_id), 32'd2);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("wr%0d_cv", k),    32'(ctl_valid), 32'd1);
         check($sformatf("wr%0d_we", k),    32'(ctl_we),    32'd1);
         check($sformatf("wr%0d_wdata", k), 32'(ctl_wdata), 32'h5A5A);
         check($sformatf("wr%0d_mask", k),  32'(ctl_mask),  32'b10);
         check($sformatf("wr%0d_addr", k),  32'(ctl_addr),  32'h0ABCDEF);
         if (k < 3) step();
      end
      ctl_accept = 1'b1;
      step();
      ctl_accept = 1'b0;
      ctl_done   = 1'b1;
      ctl_rdata  = 16'h1111;
      step();
      check("wr_ack", 32'(req_ack), 32'b100);
      check("wr_rdata_kept", 32'(req_rdata), 32'hBEEF);
      ctl_done  = 1'b0;
      req_valid = 3'b000;
      req_we    = 3'b000;
      step();

      // timeout: accepted, no done
      req_valid  = 3'b010;
      ctl_accept = 1'b1;
      step();
      check("to_gid", 32'(grant_id), 32'd1);
      step();
      ctl_accept = 1'b0;
      check("to_wait_st", 32'(dbg_state), 32'd2);
      n_wait = 1;
      for (int k = 0; k < 400; k++) begin
         step();
         if (dbg_state == 2'd2) n_wait++;
         else break;
      end
      check("to_wait_cycles", 32'(n_wait), 32'd255);
      check("to_st_ack", 32'(dbg_state), 32'd3);
      check("to_ack", 32'(req_ack), 32'b010);
      check("to_err", 32'(req_err), 32'd1);
      req_valid = 3'b000;
      step();
      check("to_err_1cyc", 32'(req_err), 32'd0);
      check("to_ack_1cyc", 32'(req_ack), 32'd0);
      req_valid  = 3'b001;
      ctl_accept = 1'b1;
      ctl_done   = 1'b1;
      ctl_rdata  = 16'h7777;
      step();
      check("to_next_gid", 32'(grant_id), 32'd0);
      step();
      check("to_next_ack", 32'(req_ack), 32'b001);
      check("to_next_err", 32'(req_err), 32'd0);
      check("to_next_rdata", 32'(req_rdata), 32'h7777);
      req_valid  = 3'b000;
      ctl_accept = 1'b0;
      ctl_done   = 1'b0;
      step();

      // async reset in the middle of WAIT
      req_valid = 3'b100;
      step();
      check("rs_gid", 32'(grant_id), 32'd2);
      ctl_accept = 1'b1;
      step();
      ctl_accept = 1'b0;
      step();
      step();
      check("rs_wait_st", 32'(dbg_state), 32'd2);
      #2;
      resetn = 1'b0;
      #1;
      check_reset_outputs("rs_async");
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rs_held");
      resetn     = 1'b1;
      req_valid  = 3'b111;
      ctl_accept = 1'b1;
      ctl_done   = 1'b1;
      step();
      check("rs_first_gid", 32'(grant_id), 32'd0);
      check("rs_first_cv", 32'(ctl_valid), 32'd1);
      step();
      check("rs_first_ack", 32'(req_ack), 32'b001);
      req_valid = 3'b000;
      step();

      // requester 0 keeps asserting alongside 1 and 2
`ifdef SDRAM_ARB_PRIO0_EN
      exp_q = '{3'd0, 3'd0, 3'd0};
`else
      exp_q = '{3'd1, 3'd2, 3'd0};
`endif
      req_valid = 3'b111;
      for (int k = 0; k < 9; k++) begin
         step();
         if (ctl_valid) begin
            if (exp_q.size() == 0) begin
               check("pr_extra_grant", 32'(grant_id), 32'hFFFF);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("pr_grant%0d", k), 32'(grant_id), 32'(e));
            end
         end
      end
      check("pr_all_grants_seen", 32'(exp_q.size()), 32'd0);
      req_valid  = 3'b000;
      ctl_accept = 1'b0;
      ctl_done   = 1'b0;
      step();

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller command port, clocked by the 100 MHz controller-phase clock, between NUM_REQ requesters (CPU instruction fetch, CPU data, display/DMA).
- Round-robin grant; one outstanding transaction at a time.
- Per-requester level-held request with a one-cycle completion acknowledge.
- Drives the controller with a valid/accept handshake, then waits for done.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- AW, 26, word address width
- DW, 16, data width
- TIMEOUT_CYC, 255, max cycles waiting for ctl_done before error abort (8-bit counter)

Ports:
- clkSDRAMcontrol  in  1  100 MHz controller clock
- resetn  in  1  async active-low reset
- req_valid  in  NUM_REQ  per-requester request, held until ack
- req_we  in  NUM_REQ  1=write
- req_addr  in  NUM_REQ*AW  packed, requester i at [i*AW +: AW]
- req_wdata  in  NUM_REQ*DW  packed write data
- req_mask  in  NUM_REQ*2  byte enables
- req_ack  out  NUM_REQ  one-hot 1-cycle completion pulse
- req_rdata  out  DW  read data, valid when any req_ack bit is set for a read
- req_err  out  1  pulses with req_ack when the transaction timed out
- ctl_valid  out  1  command valid to SDRAM controller
- ctl_accept  in  1  controller takes the command
- ctl_we, ctl_addr, ctl_wdata, ctl_mask  out  1/AW/DW/2  command fields
- ctl_done  in  1  controller completion pulse
- ctl_rdata  in  DW  read data, valid with ctl_done
- grant_id  out  3  index of current/last grantee

Behaviour:
- Reset values: req_ack=0, req_rdata=0, req_err=0, ctl_valid=0, ctl_* fields=0, grant_id=0, last-grant pointer=NUM_REQ-1, state=IDLE, timeout counter=0.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any req_valid, pick the first set bit searching from (last+1) mod NUM_REQ with wrap-around. Register the grantee's fields onto ctl_*, set ctl_valid, set grant_id, update last, go ISSUE. Decision-to-ctl_valid latency is 1 cycle.
- ISSUE: hold ctl_valid and all fields stable until ctl_accept. On accept, drop ctl_valid, clear the counter, go WAIT.
- ISSUE with ctl_accept and ctl_done in the same cycle: treat as accepted and done; go directly to ACK.
- WAIT: on ctl_done, latch ctl_rdata into req_rdata (reads only; unchanged on writes) and go ACK. Otherwise increment the counter. When counter==TIMEOUT_CYC, go ACK with the error flag set.
- ACK: assert req_ack[grant_id] and req_err (if flagged) for exactly 1 cycle, then go IDLE.
- A new grant is not issued in the ACK cycle. This gives the requester one cycle to drop or change req_valid.
- Minimum turnaround: 1 cycle back in IDLE between transactions.
- Requesters dropping req_valid after grant: ignored; the transaction completes and the ack is still issued.
- Requests arriving during non-IDLE states wait. No queueing beyond the level-held request.
- req_rdata holds its value between reads.
- Asynchronous resetn assertion mid-transaction: all outputs return to reset values immediately. An in-flight controller transaction is abandoned; the controller is reset by the same resetn.
- Width rules: grant_id zero-extended to 3 bits. Pointer arithmetic wraps mod NUM_REQ, not mod 8.

Optional Feature:
- Macro: SDRAM_ARB_PRIO0_EN.
- Defined: requester 0 (display) has fixed highest priority. If req_valid[0] is set in IDLE it wins regardless of the pointer, and the pointer is not updated on a requester-0 grant. Remaining requesters stay round-robin.
- Undefined: pure round-robin across all requesters.

Decomposition:
- Shared package sdram_arb_pkg: state encoding (IDLE=0, ISSUE=1, WAIT=2, ACK=3), default AW/DW constants, and a timeout counter width constant of 8.
- One natural sub-module: rr_pick (combinational rotate-priority encoder). Inputs: request vector and last pointer. Outputs: index and found.

Test Plan:
- Single read: req_valid=001, addr 0x0000123, ctl_accept 2 cycles after ctl_valid, ctl_done 5 cycles later with rdata 0xBEEF -> req_ack=001 for 1 cycle, req_rdata=0xBEEF, req_err=0.
- All three requesting continuously, immediate accept/done -> grants in order 0,1,2,0,1,2; each ack one-hot; 1 IDLE cycle between.
- Write: req_we=1 on requester 2, wdata 0x5A5A, mask 10 -> ctl_we=1, ctl_wdata=0x5A5A, ctl_mask=10 stable while ctl_accept is low; req_rdata unchanged.
- Timeout: accept given, no ctl_done -> after 255 WAIT cycles req_ack and req_err pulse together; next grant proceeds normally.
- Reset mid-WAIT: resetn low for 3 cycles -> ctl_valid=0 and req_ack=0 immediately; after release, the first grant goes to requester 0.
- With SDRAM_ARB_PRIO0_EN: requesters 1 and 2 pending, requester 0 asserts each IDLE -> requester 0 wins every time; without the macro -> 1 and 2 are served in turn.
